// File: rtl/wb_sched.sv
// Writeback scheduler: merges in-order pipeline writebacks with buffered
// out-of-order late results onto the single register file write port, and
// tracks which registers still owe a late result so decode can stall.
module wb_sched #(
    parameter int LR_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_reg,
    input  logic [31:0] i_wb_dat,
    input  logic        i_lr_issue,
    input  logic [4:0]  i_lr_issue_reg,
    input  logic        i_lr_valid,
    input  logic [4:0]  i_lr_reg,
    input  logic [31:0] i_lr_dat,
    output logic        o_lr_ready,
    input  logic        i_hz_rs1,
    input  logic        i_hz_rs2,
    input  logic        i_hz_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [4:0]  i_rd,
    output logic        o_hz_data,
    output logic        o_we,
    output logic [4:0]  o_addr_wr,
    output logic [31:0] o_dat_wr
);

    localparam int AW = $clog2(LR_DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [4:0]    fifo_reg [LR_DEPTH];
    logic [31:0]   fifo_dat [LR_DEPTH];
    logic [31:0]   pending;
    logic [31:0]   pending_next;
    logic          full;
    logic          push;
    logic          pop;
    logic [4:0]    head_reg;
    logic [31:0]   head_dat;

    // Handshake and FIFO control: ready comes from the registered full flag,
    // so a slot freed by this cycle's pop is not reusable until next cycle.
    always_comb begin
        full       = (count == (AW + 1)'(LR_DEPTH));
        o_lr_ready = !full && !i_rst && i_ce;
        push       = i_lr_valid && o_lr_ready;
        pop        = i_ce && !i_rst && !i_wb_valid && (count != '0);
        head_reg   = fifo_reg[rd_ptr];
        head_dat   = fifo_dat[rd_ptr];
    end

    // Late-result storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_reg[wr_ptr] <= i_lr_reg;
            fifo_dat[wr_ptr] <= i_lr_dat;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    // Scoreboard update: pop clears, issue sets, and set wins on a collision.
    always_comb begin
        pending_next = pending;
        if (pop) begin
            pending_next = pending_next & ~(32'd1 << head_reg);
        end
        if (i_ce && i_lr_issue && (i_lr_issue_reg != 5'd0)) begin
            pending_next = pending_next | (32'd1 << i_lr_issue_reg);
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard register, frozen while the clock enable is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending <= '0;
        end else if (i_ce) begin
            pending <= pending_next;
        end
    end

    // Write port register: pipeline writeback beats late results; x0 never writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_we      <= 1'b0;
            o_addr_wr <= 5'd0;
            o_dat_wr  <= 32'd0;
        end else if (i_ce) begin
            if (i_wb_valid) begin
                o_we      <= (i_wb_reg != 5'd0);
                o_addr_wr <= i_wb_reg;
                o_dat_wr  <= i_wb_dat;
            end else if (pop) begin
                o_we      <= (head_reg != 5'd0);
                o_addr_wr <= head_reg;
                o_dat_wr  <= head_dat;
            end else begin
                o_we <= 1'b0;
            end
        end
    end

    // Decode stall on RAW/WAW against any register still owed a late result.
    always_comb begin
        o_hz_data = (i_hz_rs1 && (i_rs1 != 5'd0) && pending[i_rs1])
                 || (i_hz_rs2 && (i_rs2 != 5'd0) && pending[i_rs2])
                 || (i_hz_rd  && (i_rd  != 5'd0) && pending[i_rd]);
    end

endmodule
